// File: rtl/sr_latch_en_arbiter_if.sv
// Requester-side bundle for sr_latch_en_arbiter: per-requester request/op
// lines in, one-hot grant and completion status out.
interface sr_latch_en_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] op;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic            done;
  logic            err;

  // Requester logic drives req/op and watches the status lines.
  modport master (output req, output op, input gnt, input busy, input done, input err);
  // The arbiter consumes req/op and drives the status lines.
  modport slave  (input req, input op, output gnt, output busy, output done, output err);
endinterface

// File: rtl/sr_latch_en_arbiter.sv
// Round-robin arbiter and sequencer sharing one gated SR latch between NREQ
// requesters. Each granted operation runs SETUP -> PULSE -> HOLD -> CHECK so
// that S/R are stable around both EN edges, then the latch is read back.
// Every output is a flop, loaded from the decode of the next state.
module sr_latch_en_arbiter #(
  parameter int NREQ         = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  sr_latch_en_arbiter_if.slave        bus,
  output logic                        S,
  output logic                        R,
  output logic                        EN,
  input  logic                        Q,
  input  logic                        Qbar
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [PW-1:0]   ptr, ptr_next;
  logic [PW-1:0]   gidx, gidx_next;
  logic            cur_op, cur_op_next;
  logic [PW-1:0]   pick_idx;
  logic            pick_valid;
  logic [PW:0]     cand;
  logic [NREQ-1:0] gnt_next;
  logic            busy_next, done_next, err_next;
  logic            s_next, r_next, en_next;

  // Pick the first requesting index at or after the pointer (wrapping);
  // scanning downward lets the lowest offset win the final write.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (PW + 1)'(i);
      if (cand >= (PW + 1)'(NREQ)) begin
        cand = cand - (PW + 1)'(NREQ);
      end else begin
        cand = cand;
      end
      if (bus.req[cand[PW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[PW-1:0];
      end else begin
        pick_valid = pick_valid;
      end
    end
  end

  // Next-state sequencing and the output values to be registered with it.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    ptr_next    = ptr;
    gidx_next   = gidx;
    cur_op_next = cur_op;
    gnt_next    = '0;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    err_next    = 1'b0;
    s_next      = 1'b0;
    r_next      = 1'b0;
    en_next     = 1'b0;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next  = SETUP;
          gidx_next   = pick_idx;
          cur_op_next = bus.op[pick_idx];
        end else begin
          state_next  = IDLE;
        end
      end
      SETUP: begin
        state_next = PULSE;
        cnt_next   = CW'(PULSE_CYCLES - 1);
      end
      PULSE: begin
        if (cnt == '0) begin
          state_next = HOLD;
          cnt_next   = CW'(HOLD_CYCLES - 1);
        end else begin
          cnt_next   = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_next = CHECK;
        end else begin
          cnt_next   = cnt - CW'(1);
        end
      end
      CHECK: begin
        state_next = IDLE;
        if (gidx == PW'(NREQ - 1)) begin
          ptr_next = '0;
        end else begin
          ptr_next = gidx + PW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // S/R stay fixed from SETUP through HOLD, so EN never moves with them.
    case (state_next)
      IDLE: begin
        gnt_next = '0;
      end
      SETUP, PULSE, HOLD: begin
        gnt_next  = {{(NREQ - 1){1'b0}}, 1'b1} << gidx_next;
        busy_next = 1'b1;
        s_next    = cur_op_next;
        r_next    = ~cur_op_next;
        en_next   = (state_next == PULSE);
      end
      CHECK: begin
        gnt_next  = {{(NREQ - 1){1'b0}}, 1'b1} << gidx_next;
        busy_next = 1'b1;
        done_next = 1'b1;
        err_next  = (Q != cur_op_next) || (Qbar != ~Q);
      end
      default: begin
        gnt_next = '0;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      gidx     <= '0;
      cur_op   <= 1'b0;
      bus.gnt  <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      S        <= 1'b0;
      R        <= 1'b0;
      EN       <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      ptr      <= ptr_next;
      gidx     <= gidx_next;
      cur_op   <= cur_op_next;
      bus.gnt  <= gnt_next;
      bus.busy <= busy_next;
      bus.done <= done_next;
      bus.err  <= err_next;
      S        <= s_next;
      R        <= r_next;
      EN       <= en_next;
    end
  end

endmodule

// File: doc/sr_latch_en_arbiter.md
Name: sr_latch_en_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one sr_latch_en instance between NREQ requesters.
- Each requester asks for a SET or RESET operation. The block drives S, R and EN in a glitch-free sequence (data setup, enable pulse, hold, release) and never drives S=R=1.
- After the sequence it reads back Q/Qbar to confirm the operation and signals completion to the granted requester.
- Sits between requester logic and the latch instance; all outputs are registered.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PULSE_CYCLES, 2, cycles EN is held at 1 (>=1).
- HOLD_CYCLES, 1, cycles S/R are held stable after EN falls (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  request per requester; level, held until done.
- op  input  NREQ  operation per requester: 1 = SET, 0 = RESET; sampled at grant.
- gnt  output  NREQ  one-hot grant; asserted from SETUP through CHECK.
- busy  output  1  1 whenever state != IDLE.
- done  output  1  one-cycle pulse in CHECK.
- err  output  1  valid with done: 1 if readback mismatched.
- S  output  1  to latch S.
- R  output  1  to latch R.
- EN  output  1  to latch EN.
- Q  input  1  latch Q.
- Qbar  input  1  latch Qbar.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, gnt=0, busy=0, done=0, err=0, S=0, R=0, EN=0, round-robin pointer=0. Reset mid-transaction aborts immediately; EN drops the cycle after reset is sampled.
- States: IDLE, SETUP, PULSE, HOLD, CHECK.
- IDLE:
  - S=R=EN=0.
  - If any req is 1, grant the first requester at or after the pointer, wrapping from NREQ-1 to 0. Latch its op into cur_op and go to SETUP.
  - If no req, stay in IDLE.
- SETUP, 1 cycle: gnt set, busy=1, S=cur_op, R=~cur_op, EN=0. Next state is PULSE.
- PULSE, PULSE_CYCLES cycles: EN=1, S/R unchanged. Next state is HOLD.
- HOLD, HOLD_CYCLES cycles: EN=0, S/R unchanged, so data is stable across the EN falling edge. Next state is CHECK.
- CHECK, 1 cycle:
  - S=R=EN=0, done=1.
  - err=1 if Q != cur_op or Qbar != ~Q, else err=0.
  - Pointer = granted index + 1 (mod NREQ).
  - Next state is IDLE, where gnt=0 and done=0.
- Latency:
  - Request seen in IDLE at cycle t: gnt and SETUP at t+1; EN=1 over t+2..t+1+PULSE_CYCLES.
  - done at t+2+PULSE_CYCLES+HOLD_CYCLES (t+5 with defaults).
  - Minimum one IDLE cycle between transactions.
- Invariants:
  - S and R are never both 1.
  - S/R never change in the same cycle EN changes.
  - gnt is one-hot or zero.
- Requester dropping req mid-transaction: the transaction completes normally and done is still pulsed.
- req/op changes after grant are ignored; op is sampled only at the IDLE->SETUP transition.
- A request rising in the CHECK cycle is considered in the following IDLE cycle.
- Simultaneous requests are resolved by the pointer only (round robin); no requester is starved. Worst-case wait is NREQ-1 transactions.
- err is not sticky; it is cleared to 0 in IDLE.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 -> gnt=0, S=R=EN=0, busy=0, done=0 indefinitely.
- Single SET: req=4'b0001, op[0]=1 at t, latch model attached:
  - gnt=0001 at t+1; S=1, R=0 from t+1 to t+4; EN=1 at t+2..t+3.
  - done=1, err=0 at t+5, with Q=1, Qbar=0.
- Round robin: all four req=1 held continuously, pointer=0 -> grants in order 0001, 0010, 0100, 1000, 0001. Each done is followed by one IDLE cycle.
- Alternating ops: requester 2 RESET, then requester 3 SET -> Q=0 after the first done, Q=1 after the second. S=R=1 is never observed; S/R never toggle in the same cycle as EN.
- Readback fault: force Q=0 during a SET -> done=1 with err=1; err=0 in the next IDLE cycle.
- Reset mid-pulse: assert rst during the first PULSE cycle -> the next cycle has EN=0, gnt=0, busy=0, pointer=0, and no done pulse.
